// File: rtl/pxie_c2h_read_engine.sv
// Card-to-host readback engine: captures a c2h request, prefetches words from
// the RAM read port into a credit-limited FIFO and streams them to TX behind a
// single header beat over a valid/ready handshake.
// Ports:
//   I_PXIE_CLK, I_Rst_n                 clock, async active-low reset
//   I_c2h_addr/len/en                   request from the RX command decoder
//   O_ram_addr, O_ram_rden, I_ram_rdata RAM read port (fixed RAM_LAT latency)
//   O_tx_data/vld/last, I_tx_rdy        TX beat stream
//   O_busy, O_done, O_drop_cnt          status
module pxie_c2h_read_engine #(
  parameter int unsigned RAM_AW     = 16,
  parameter int unsigned RAM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              I_PXIE_CLK,
  input  logic              I_Rst_n,
  input  logic [15:0]       I_c2h_addr,
  input  logic [15:0]       I_c2h_len,
  input  logic              I_c2h_en,
  output logic [RAM_AW-1:0] O_ram_addr,
  output logic              O_ram_rden,
  input  logic [127:0]      I_ram_rdata,
  output logic [127:0]      O_tx_data,
  output logic              O_tx_vld,
  input  logic              I_tx_rdy,
  output logic              O_tx_last,
  output logic              O_busy,
  output logic              O_done,
  output logic [7:0]        O_drop_cnt
);

  localparam int unsigned DW = 128;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [15:0] HDR_TAG = 16'heb9d;

  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_DATA, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_en_q1;
  logic              r_en_q2;
  logic [15:0]       r_addr;
  logic [15:0]       r_len;
  logic [15:0]       r_issued;
  logic [15:0]       r_sent;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [RAM_LAT-1:0] r_vld_pipe;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;
  logic [DW-1:0]     r_mem [FIFO_DEPTH];
  logic [7:0]        r_drop_cnt;

  logic              w_req_edge;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_empty;
  logic              w_can_read;
  logic              w_xfer;
  logic              w_last_beat;
  logic [CW-1:0]     w_fifo_cnt;
  logic [SW-1:0]     w_occupancy;
  logic [DW-1:0]     w_hdr;

  assign w_req_edge  = r_en_q1 & ~r_en_q2;
  assign w_fifo_cnt  = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_fifo_cnt == '0);
  // Reads in flight count against FIFO space so a landing word always has a slot.
  assign w_occupancy = SW'(w_fifo_cnt) + SW'(r_inflight);
  assign w_can_read  = (r_issued < r_len) && (w_occupancy < SW'(FIFO_DEPTH));
  assign w_fifo_wr   = r_vld_pipe[RAM_LAT-1];
  assign w_xfer      = O_tx_vld & I_tx_rdy;
  assign w_fifo_rd   = (r_state == ST_DATA) && w_xfer;
  assign w_last_beat = (r_sent == r_len - 16'd1);
  assign w_hdr       = {64'h0, HDR_TAG, r_len, 16'h0, r_addr};

  // FSM state register
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_edge) w_state_nxt = ST_HEAD;
      ST_HEAD: if (w_xfer) w_state_nxt = (r_len == 16'd0) ? ST_DONE : ST_DATA;
      ST_DATA: if (w_xfer && w_last_beat) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; idle decodes to all-zero so reset clears outputs at once
  always_comb begin
    O_tx_vld   = 1'b0;
    O_tx_data  = '0;
    O_tx_last  = 1'b0;
    O_busy     = 1'b0;
    O_done     = 1'b0;
    O_ram_rden = 1'b0;
    O_ram_addr = r_ram_addr;
    O_drop_cnt = r_drop_cnt;
    case (r_state)
      ST_HEAD: begin
        O_tx_vld   = 1'b1;
        O_tx_data  = w_hdr;
        O_tx_last  = (r_len == 16'd0);
        O_busy     = 1'b1;
        O_ram_rden = w_can_read;
      end
      ST_DATA: begin
        O_tx_vld   = ~w_empty;
        O_tx_data  = r_mem[r_rd_ptr[PW-1:0]];
        O_tx_last  = w_last_beat;
        O_busy     = 1'b1;
        O_ram_rden = w_can_read;
      end
      ST_DONE: begin
        O_done = 1'b1;
        O_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture, counters, read tracking and FIFO pointers
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      r_en_q1    <= 1'b0;
      r_en_q2    <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_ram_addr <= '0;
      r_vld_pipe <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_en_q1 <= I_c2h_en;
      r_en_q2 <= r_en_q1;
      if (r_state == ST_IDLE && w_req_edge) begin
        r_addr     <= I_c2h_addr;
        r_len      <= I_c2h_len;
        r_issued   <= '0;
        r_sent     <= '0;
        r_ram_addr <= RAM_AW'(I_c2h_addr);
      end else begin
        if (O_ram_rden) begin
          r_issued   <= r_issued + 16'd1;
          r_ram_addr <= r_ram_addr + RAM_AW'(1);
        end
        if (w_fifo_rd) r_sent <= r_sent + 16'd1;
      end
      if (w_req_edge && r_state != ST_IDLE && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
      // Valid bits march alongside the RAM pipeline; the oldest marks a landing word.
      r_vld_pipe <= RAM_LAT'({r_vld_pipe, O_ram_rden});
      r_inflight <= r_inflight + CW'(O_ram_rden) - CW'(w_fifo_wr);
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge I_PXIE_CLK) begin
    if (w_fifo_wr) r_mem[r_wr_ptr[PW-1:0]] <= I_ram_rdata;
  end

endmodule

// File: tb/tb_pxie_c2h_read_engine.sv
module tb_pxie_c2h_read_engine;

  localparam int unsigned FIFO_DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  c2h_addr = '0;
  logic [15:0]  c2h_len = '0;
  logic         c2h_en = 1'b0;
  logic [15:0]  ram_addr;
  logic         ram_rden;
  logic [127:0] ram_rdata;
  logic [127:0] tx_data;
  logic         tx_vld;
  logic         tx_rdy = 1'b0;
  logic         tx_last;
  logic         busy;
  logic         done;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int failures = 0;

  pxie_c2h_read_engine #(.RAM_AW(16), .RAM_LAT(2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .I_PXIE_CLK(clk), .I_Rst_n(rst_n),
    .I_c2h_addr(c2h_addr), .I_c2h_len(c2h_len), .I_c2h_en(c2h_en),
    .O_ram_addr(ram_addr), .O_ram_rden(ram_rden), .I_ram_rdata(ram_rdata),
    .O_tx_data(tx_data), .O_tx_vld(tx_vld), .I_tx_rdy(tx_rdy), .O_tx_last(tx_last),
    .O_busy(busy), .O_done(done), .O_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i, two-cycle read latency
  logic [15:0] ra_q1 = '0;
  logic [15:0] ra_q2 = '0;
  always @(posedge clk) begin
    ra_q1 <= ram_addr;
    ra_q2 <= ra_q1;
  end
  assign ram_rdata = 128'(ra_q2);

  // Monitor: samples just after the falling edge, i.e. the values the next rising edge sees
  logic [128:0] beats[$];
  logic [15:0]  rd_log[$];
  int n_rden = 0, n_data = 0, n_done = 0, stab_viol = 0, ovf_viol = 0;
  logic in_pkt = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
  logic [128:0] p_beat = '0;

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      in_pkt = 1'b0; p_vld = 1'b0; n_rden = 0; n_data = 0;
    end else begin
      if (p_vld && !p_rdy && (!tx_vld || {tx_last, tx_data} !== p_beat)) stab_viol++;
      if (ram_rden) begin rd_log.push_back(ram_addr); n_rden++; end
      if (done) n_done++;
      if (tx_vld && tx_rdy) begin
        beats.push_back({tx_last, tx_data});
        if (in_pkt) n_data++;
        in_pkt = !tx_last;
      end
      if (n_rden - n_data > int'(FIFO_DEPTH)) ovf_viol++;
      p_vld = tx_vld; p_rdy = tx_rdy; p_beat = {tx_last, tx_data};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_req(input logic [15:0] a, input logic [15:0] l);
    @(negedge clk);
    c2h_addr = a; c2h_len = l; c2h_en = 1'b1;
    @(negedge clk);
    c2h_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    int d0;
    d0 = n_done;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rnd) tx_rdy = 1'($urandom_range(0, 1));
      if (n_done != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_addr, ram_rden, tx_data, tx_vld, tx_last, busy, done, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: vld=%b rden=%b busy=%b done=%b drop=%0d data=%h expected all zero",
               tx_vld, ram_rden, busy, done, drop_cnt, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    int d0;
    logic [128:0] exp;
    beats.delete(); rd_log.delete(); tx_rdy = 1'b1; d0 = n_done;
    @(negedge clk);
    c2h_addr = 16'h0010; c2h_len = 16'd4; c2h_en = 1'b1;
    @(negedge clk);
    c2h_en = 1'b0;
    checks++;
    if (tx_vld !== 1'b0) begin failures++; $display("FAIL basic_lat1: tx_vld=%b expected 0", tx_vld); end
    @(negedge clk);
    checks++;
    if ({tx_vld, busy} !== 2'b11) begin failures++; $display("FAIL basic_lat2: vld,busy=%b expected 11", {tx_vld, busy}); end
    wait_done(60, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: done=0 expected 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (n_done - d0 !== 1) begin failures++; $display("FAIL basic_done_cnt: %0d expected 1", n_done - d0); end
    checks++;
    if (beats.size() !== 5) begin failures++; $display("FAIL basic_beats: %0d expected 5", beats.size()); end
    checks++;
    if (beats[0] !== {1'b0, 64'h0, 16'heb9d, 16'h0004, 16'h0000, 16'h0010}) begin
      failures++; $display("FAIL basic_header: %h expected eb9d00040000_0010 last=0", beats[0]);
    end
    for (int j = 0; j < 4; j++) begin
      exp = {1'(j == 3), 128'(16'h0010 + 16'(j))};
      checks++;
      if (beats[j+1] !== exp) begin failures++; $display("FAIL basic_data%0d: %h expected %h", j, beats[j+1], exp); end
    end
    checks++;
    if (rd_log.size() !== 4 || rd_log[0] !== 16'h0010 || rd_log[3] !== 16'h0013) begin
      failures++; $display("FAIL basic_reads: count=%0d first=%h last=%h expected 4 0010 0013",
                           rd_log.size(), rd_log[0], rd_log[rd_log.size()-1]);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: %b expected 0", busy); end
  endtask

  task automatic test_len0;
    bit ok;
    int d0;
    beats.delete(); rd_log.delete(); tx_rdy = 1'b1; d0 = n_done;
    send_req(16'h1234, 16'd0);
    wait_done(30, 1'b0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || n_done - d0 !== 1) begin failures++; $display("FAIL len0_done: pulses=%0d expected 1", n_done - d0); end
    checks++;
    if (beats.size() !== 1 || beats[0] !== {1'b1, 64'h0, 16'heb9d, 16'h0000, 16'h0000, 16'h1234}) begin
      failures++; $display("FAIL len0_header: n=%0d beat=%h expected 1 beat last=1 eb9d0000_0000_1234", beats.size(), beats[0]);
    end
    checks++;
    if (rd_log.size() !== 0) begin failures++; $display("FAIL len0_rden: %0d reads expected 0", rd_log.size()); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [15:0] exp_a [4];
    logic [128:0] exp;
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    beats.delete(); rd_log.delete(); tx_rdy = 1'b1;
    send_req(16'hFFFE, 16'd4);
    wait_done(60, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_timeout: done=0 expected 1"); end
    checks++;
    if (rd_log.size() !== 4) begin failures++; $display("FAIL wrap_reads: %0d expected 4", rd_log.size()); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rd_log[j] !== exp_a[j]) begin failures++; $display("FAIL wrap_addr%0d: %h expected %h", j, rd_log[j], exp_a[j]); end
      exp = {1'(j == 3), 128'(exp_a[j])};
      checks++;
      if (beats[j+1] !== exp) begin failures++; $display("FAIL wrap_data%0d: %h expected %h", j, beats[j+1], exp); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad;
    logic [128:0] exp;
    beats.delete(); rd_log.delete(); stab_viol = 0; ovf_viol = 0; tx_rdy = 1'b0;
    send_req(16'h0200, 16'd32);
    repeat (15) @(negedge clk);
    checks++;
    if (rd_log.size() !== 8 || ram_rden !== 1'b0 || tx_vld !== 1'b1) begin
      failures++; $display("FAIL bp_stall: reads=%0d rden=%b vld=%b expected 8 0 1", rd_log.size(), ram_rden, tx_vld);
    end
    wait_done(2000, 1'b1, ok);
    tx_rdy = 1'b1;
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: done=0 expected 1"); end
    checks++;
    if (beats.size() !== 33) begin failures++; $display("FAIL bp_beats: %0d expected 33", beats.size()); end
    checks++;
    if (beats[0] !== {1'b0, 64'h0, 16'heb9d, 16'h0020, 16'h0000, 16'h0200}) begin
      failures++; $display("FAIL bp_header: %h expected eb9d0020_0000_0200", beats[0]);
    end
    bad = 0;
    for (int j = 0; j < 32; j++) begin
      exp = {1'(j == 31), 128'(16'h0200 + 16'(j))};
      if (beats[j+1] !== exp || rd_log[j] !== 16'h0200 + 16'(j)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_order: %0d wrong beats/reads expected 0", bad); end
    checks++;
    if (stab_viol != 0) begin failures++; $display("FAIL bp_stable: %0d unstable cycles expected 0", stab_viol); end
    checks++;
    if (ovf_viol != 0) begin failures++; $display("FAIL bp_overflow: %0d cycles over depth expected 0", ovf_viol); end
  endtask

  task automatic test_drop;
    bit ok;
    int bad;
    logic [128:0] exp;
    beats.delete(); tx_rdy = 1'b1;
    send_req(16'h0300, 16'd16);
    repeat (4) @(negedge clk);
    c2h_addr = 16'h0700; c2h_len = 16'd2; c2h_en = 1'b1;
    @(negedge clk);
    c2h_en = 1'b0;
    wait_done(100, 1'b0, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_cnt: %0d expected 1", drop_cnt); end
    checks++;
    if (beats.size() !== 17 || beats[0] !== {1'b0, 64'h0, 16'heb9d, 16'h0010, 16'h0000, 16'h0300}) begin
      failures++; $display("FAIL drop_header: n=%0d beat=%h expected 17 eb9d0010_0000_0300", beats.size(), beats[0]);
    end
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      exp = {1'(j == 15), 128'(16'h0300 + 16'(j))};
      if (beats[j+1] !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL drop_data: %0d wrong beats expected 0", bad); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_restart: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0;
    beats.delete(); tx_rdy = 1'b1; d0 = n_done;
    send_req(16'h0400, 16'd16);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || beats.size() < 2) begin
      failures++; $display("FAIL rst_mid_state: busy=%b beats=%0d expected 1 >=2", busy, beats.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_rden, tx_data, tx_vld, tx_last, busy, done, drop_cnt} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs: vld=%b rden=%b busy=%b done=%b drop=%0d expected all zero",
                           tx_vld, ram_rden, busy, done, drop_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_done !== d0) begin failures++; $display("FAIL rst_mid_no_done: %0d pulses expected 0", n_done - d0); end
    beats.delete(); rd_log.delete();
    send_req(16'h0500, 16'd3);
    wait_done(60, 1'b0, ok);
    checks++;
    if (!ok || beats.size() !== 4) begin failures++; $display("FAIL rst_after_beats: %0d expected 4", beats.size()); end
    checks++;
    if (beats[0] !== {1'b0, 64'h0, 16'heb9d, 16'h0003, 16'h0000, 16'h0500} ||
        beats[1] !== {1'b0, 128'h0500} || beats[3] !== {1'b1, 128'h0502}) begin
      failures++; $display("FAIL rst_after_data: hdr=%h d0=%h d2=%h expected eb9d0003..0500 0500 last:0502",
                           beats[0], beats[1], beats[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
